// File: rtl/play_area_ctrl.sv
// Single-port owner of the play_area cell RAM: clear sweep, one-cycle video reads,
// and handshaked game reads/writes guarded against starvation by video traffic.
module play_area_ctrl #(
    parameter int WIDTH        = 80,
    parameter int HEIGHT       = 60,
    parameter int BIT_DEPTH    = 3,
    parameter int CLEAR_VALUE  = 0,
    parameter int STARVE_LIMIT = 255,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clear_start,
    output logic                 o_clearing,
    input  logic                 i_vid_req,
    input  logic [XW-1:0]        i_vid_x,
    input  logic [YW-1:0]        i_vid_y,
    output logic                 o_vid_valid,
    output logic [BIT_DEPTH-1:0] o_vid_data,
    input  logic                 i_game_req,
    input  logic                 i_game_we,
    input  logic [XW-1:0]        i_game_x,
    input  logic [YW-1:0]        i_game_y,
    input  logic [BIT_DEPTH-1:0] i_game_wdata,
    output logic                 o_game_ack,
    output logic [BIT_DEPTH-1:0] o_game_rdata,
    output logic [XW-1:0]        o_mem_x,
    output logic [YW-1:0]        o_mem_y,
    output logic                 o_mem_we,
    output logic [BIT_DEPTH-1:0] o_mem_wdata,
    input  logic [BIT_DEPTH-1:0] i_mem_rdata
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [BIT_DEPTH-1:0] LP_CLEAR = BIT_DEPTH'(CLEAR_VALUE);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t          r_state;
    logic [XW-1:0]   r_sweep_x;
    logic [YW-1:0]   r_sweep_y;
    logic [XW-1:0]   r_last_x;
    logic [YW-1:0]   r_last_y;
    logic [SW-1:0]   r_starve;
    logic            r_vid_valid;
    logic            r_vid_from_mem;
    logic            r_game_ack;

    logic w_run;
    logic w_game_pend;
    logic w_starve_fire;
    logic w_vid_issue;
    logic w_game_issue;

    // A game request whose ack is showing this cycle was issued last cycle; never reissue it.
    assign w_run         = (r_state == S_RUN);
    assign w_game_pend   = i_game_req && !r_game_ack;
    assign w_starve_fire = (STARVE_LIMIT != 0) && (r_starve == SW'(STARVE_LIMIT)) && w_game_pend;
    assign w_vid_issue   = w_run && i_vid_req && !w_starve_fire;
    assign w_game_issue  = w_run && w_game_pend && !w_vid_issue;

    always_comb begin
        o_mem_x     = r_last_x;
        o_mem_y     = r_last_y;
        o_mem_we    = 1'b0;
        o_mem_wdata = i_game_wdata;
        if (!w_run) begin
            o_mem_x     = r_sweep_x;
            o_mem_y     = r_sweep_y;
            o_mem_we    = 1'b1;
            o_mem_wdata = LP_CLEAR;
        end else if (w_vid_issue) begin
            o_mem_x = i_vid_x;
            o_mem_y = i_vid_y;
        end else if (w_game_issue) begin
            o_mem_x  = i_game_x;
            o_mem_y  = i_game_y;
            o_mem_we = i_game_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_CLEAR;
            r_sweep_x      <= '0;
            r_sweep_y      <= '0;
            r_last_x       <= '0;
            r_last_y       <= '0;
            r_starve       <= '0;
            r_vid_valid    <= 1'b0;
            r_vid_from_mem <= 1'b0;
            r_game_ack     <= 1'b0;
        end else begin
            r_vid_valid    <= w_vid_issue || (!w_run && i_vid_req);
            r_vid_from_mem <= w_vid_issue;
            r_game_ack     <= w_game_issue;
            r_last_x       <= o_mem_x;
            r_last_y       <= o_mem_y;

            if (w_game_issue)
                r_starve <= '0;
            else if (w_run && w_game_pend && STARVE_LIMIT != 0)
                r_starve <= r_starve + SW'(1);

            // The sweep counter always wraps back to (0,0), so a later clear starts there.
            case (r_state)
                S_CLEAR: begin
                    if (r_sweep_x == XW'(WIDTH - 1)) begin
                        r_sweep_x <= '0;
                        if (r_sweep_y == YW'(HEIGHT - 1)) begin
                            r_sweep_y <= '0;
                            r_state   <= S_RUN;
                        end else begin
                            r_sweep_y <= r_sweep_y + YW'(1);
                        end
                    end else begin
                        r_sweep_x <= r_sweep_x + XW'(1);
                    end
                end
                S_RUN: begin
                    if (i_clear_start)
                        r_state <= S_CLEAR;
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign o_clearing   = (r_state == S_CLEAR);
    assign o_vid_valid  = r_vid_valid;
    assign o_vid_data   = r_vid_valid ? (r_vid_from_mem ? i_mem_rdata : LP_CLEAR) : '0;
    assign o_game_ack   = r_game_ack;
    assign o_game_rdata = r_game_ack ? i_mem_rdata : '0;

endmodule

// File: tb/tb_play_area_ctrl.sv
// Bench for play_area_ctrl on a 4x3 board: directed scenarios then random traffic,
// every cycle checked against a board-level reference model.
module tb_play_area_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int BD = 3;
    localparam int CV = 0;
    localparam int SL = 3;

    logic          clk = 1'b0;
    logic          reset, clearStart, clearing;
    logic          vidReq, vidValid;
    logic [1:0]    vidX, vidY;
    logic [BD-1:0] vidData;
    logic          gameReq, gameWe, gameAck;
    logic [1:0]    gameX, gameY;
    logic [BD-1:0] gameWdata, gameRdata;
    logic [1:0]    memX, memY;
    logic          memWe;
    logic [BD-1:0] memWdata, memRdata;
    logic          paInit;

    always #5 clk = ~clk;

    play_area_ctrl #(
        .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .CLEAR_VALUE(CV), .STARVE_LIMIT(SL)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_clear_start(clearStart), .o_clearing(clearing),
        .i_vid_req(vidReq), .i_vid_x(vidX), .i_vid_y(vidY),
        .o_vid_valid(vidValid), .o_vid_data(vidData),
        .i_game_req(gameReq), .i_game_we(gameWe), .i_game_x(gameX), .i_game_y(gameY),
        .i_game_wdata(gameWdata), .o_game_ack(gameAck), .o_game_rdata(gameRdata),
        .o_mem_x(memX), .o_mem_y(memY), .o_mem_we(memWe), .o_mem_wdata(memWdata),
        .i_mem_rdata(memRdata)
    );

    // play_area stand-in: registered read, write echo, zero for out-of-range cells.
    logic [BD-1:0] pa [0:W*H-1];
    always @(posedge clk) begin
        if (paInit) begin
            for (int i = 0; i < W*H; i++) pa[i] <= BD'(i * 3 + 1);
            memRdata <= '0;
        end else if (int'(memX) < W && int'(memY) < H) begin
            if (memWe) pa[int'(memY)*W + int'(memX)] <= memWdata;
            memRdata <= memWe ? memWdata : pa[int'(memY)*W + int'(memX)];
        end else begin
            memRdata <= '0;
        end
    end

    int nVectors = 0;
    int nChecks  = 0;
    int nMiss    = 0;
    bit checkEn  = 0;

    // Reference model: expected board contents plus what each output should show this cycle.
    logic [BD-1:0] board [0:H-1][0:W-1];
    int            mRemain;
    bit            mVidV, mAck;
    logic [BD-1:0] mVidD, mRd;
    int            mStarve;

    bit            obsAck, obsVidValid, obsClearing, obsMemWe;
    logic [BD-1:0] obsVidData, obsRdata;
    logic [1:0]    obsMemX, obsMemY;

    function automatic logic [BD-1:0] boardRead(int x, int y);
        if (x < W && y < H) return board[y][x];
        return '0;
    endfunction

    function automatic void arbitrate(output bit vw, output bit gg);
        bit pend, fire;
        vw = 0;
        gg = 0;
        if (mRemain == 0) begin
            pend = gameReq && !mAck;
            fire = (SL != 0) && (mStarve == SL) && pend;
            vw   = vidReq && !fire;
            gg   = pend && !vw;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nMiss++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic updateModel(input bit vw, input bit gg);
        int idx;
        if (reset) begin
            mRemain = W * H;
            mVidV = 0; mVidD = '0; mAck = 0; mRd = '0; mStarve = 0;
        end else if (mRemain > 0) begin
            idx = W * H - mRemain;
            board[idx / W][idx % W] = BD'(CV);
            mRemain--;
            mVidV = vidReq;
            mVidD = vidReq ? BD'(CV) : '0;
            mAck  = 0;
            mRd   = '0;
        end else begin
            bit pend = gameReq && !mAck;
            mVidV = vw;
            mVidD = vw ? boardRead(int'(vidX), int'(vidY)) : '0;
            mAck  = gg;
            mRd   = '0;
            if (gg) begin
                if (gameWe) begin
                    mRd = (int'(gameX) < W && int'(gameY) < H) ? gameWdata : '0;
                    if (int'(gameX) < W && int'(gameY) < H) board[gameY][gameX] = gameWdata;
                end else begin
                    mRd = boardRead(int'(gameX), int'(gameY));
                end
                mStarve = 0;
            end else if (pend) begin
                mStarve++;
            end
            if (clearStart) mRemain = W * H;
        end
    endtask

    task automatic applyStimulus();
        bit vw, gg;
        int idx;
        #3;
        arbitrate(vw, gg);
        obsAck = gameAck; obsVidValid = vidValid; obsVidData = vidData; obsRdata = gameRdata;
        obsClearing = clearing; obsMemX = memX; obsMemY = memY; obsMemWe = memWe;
        if (checkEn) begin
            checkOutput("clearing", 32'(clearing), 32'(mRemain > 0));
            checkOutput("vid_valid", 32'(vidValid), 32'(mVidV));
            checkOutput("vid_data", 32'(vidData), 32'(mVidD));
            checkOutput("game_ack", 32'(gameAck), 32'(mAck));
            checkOutput("game_rdata", 32'(gameRdata), 32'(mRd));
            if (mRemain > 0) begin
                idx = W * H - mRemain;
                checkOutput("sweep_we", 32'(memWe), 32'(1));
                checkOutput("sweep_x", 32'(memX), 32'(idx % W));
                checkOutput("sweep_y", 32'(memY), 32'(idx / W));
                checkOutput("sweep_wdata", 32'(memWdata), 32'(CV));
            end else if (vw) begin
                checkOutput("vid_we", 32'(memWe), 32'(0));
                checkOutput("vid_x", 32'(memX), 32'(vidX));
                checkOutput("vid_y", 32'(memY), 32'(vidY));
            end else if (gg) begin
                checkOutput("game_we", 32'(memWe), 32'(gameWe));
                checkOutput("game_x", 32'(memX), 32'(gameX));
                checkOutput("game_y", 32'(memY), 32'(gameY));
                if (gameWe) checkOutput("game_wdata", 32'(memWdata), 32'(gameWdata));
            end else begin
                checkOutput("idle_we", 32'(memWe), 32'(0));
            end
        end
        @(posedge clk);
        updateModel(vw, gg);
        #1;
        nVectors++;
    endtask

    task automatic gameTxn(input bit we, input int x, input int y, input int d,
                           output int cyc, output logic [BD-1:0] rd);
        gameWe = we; gameX = 2'(x); gameY = 2'(y); gameWdata = BD'(d); gameReq = 1;
        cyc = -1;
        rd  = '0;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus();
            if (obsAck) begin
                cyc = i;
                rd  = obsRdata;
                break;
            end
        end
        gameReq = 0;
    endtask

    initial begin
        int cyc, cnt, ackAt, invAt, invalids;
        bit ackSeen, clearAtAck, gameActive;
        logic [BD-1:0] rd;

        reset = 1; clearStart = 0; vidReq = 0; vidX = 0; vidY = 0;
        gameReq = 0; gameWe = 0; gameX = 0; gameY = 0; gameWdata = 0; paInit = 1;
        mRemain = W * H; mVidV = 0; mVidD = '0; mAck = 0; mRd = '0; mStarve = 0;
        applyStimulus();
        paInit = 0;
        checkEn = 1;
        applyStimulus();
        reset = 0;

        // Post-reset sweep length and order.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (!obsClearing) break;
            cnt++;
        end
        checkOutput("sweep_len", 32'(cnt), 32'(W * H));

        // Back-to-back write then read of (2,1).
        gameTxn(1, 2, 1, 5, cyc, rd);
        checkOutput("wr_latency", 32'(cyc), 32'(2));
        checkOutput("wr_echo", 32'(rd), 32'(5));
        gameTxn(0, 2, 1, 0, cyc, rd);
        checkOutput("rd_latency", 32'(cyc), 32'(2));
        checkOutput("rd_data", 32'(rd), 32'(5));
        gameReq = 1;
        applyStimulus();
        checkOutput("no_ack_after_ack", 32'(obsAck), 32'(0));
        gameReq = 0;
        applyStimulus();

        // Starve guard against continuous video.
        vidReq = 1; vidX = 0; vidY = 0;
        applyStimulus();
        gameWe = 0; gameX = 3; gameY = 2; gameReq = 1;
        ackAt = 0; invAt = 0; invalids = 0;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus();
            if (obsAck && ackAt == 0) begin
                ackAt = i;
                gameReq = 0;
            end
            if (!obsVidValid) begin
                invalids++;
                invAt = i;
            end
        end
        vidReq = 0;
        checkOutput("starve_ack_cycle", 32'(ackAt), 32'(5));
        checkOutput("starve_drops", 32'(invalids), 32'(1));
        checkOutput("starve_drop_cycle", 32'(invAt), 32'(5));
        applyStimulus();

        // clear_start while a game read is in flight, video and game during the sweep.
        gameWe = 0; gameX = 2; gameY = 1; gameReq = 1; clearStart = 1;
        applyStimulus();
        clearStart = 0; gameReq = 0; vidReq = 1; vidX = 1; vidY = 1;
        applyStimulus();
        checkOutput("inflight_ack", 32'(obsAck), 32'(1));
        checkOutput("inflight_rdata", 32'(obsRdata), 32'(5));
        checkOutput("clear_rise", 32'(obsClearing), 32'(1));
        vidReq = 0; gameWe = 0; gameX = 0; gameY = 0; gameReq = 1;
        applyStimulus();
        checkOutput("sweep_vid_valid", 32'(obsVidValid), 32'(1));
        checkOutput("sweep_vid_data", 32'(obsVidData), 32'(CV));
        ackSeen = 0; clearAtAck = 1;
        for (int i = 0; i < 30; i++) begin
            applyStimulus();
            if (obsAck) begin
                ackSeen = 1;
                clearAtAck = obsClearing;
                break;
            end
        end
        gameReq = 0;
        checkOutput("sweep_game_ack", 32'(ackSeen), 32'(1));
        checkOutput("ack_after_clear", 32'(clearAtAck), 32'(0));

        // Written cell is cleared by a later sweep.
        gameTxn(1, 1, 1, 7, cyc, rd);
        checkOutput("wr7_echo", 32'(rd), 32'(7));
        clearStart = 1;
        applyStimulus();
        clearStart = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus();
            if (!obsClearing) break;
        end
        vidReq = 1; vidX = 1; vidY = 1;
        applyStimulus();
        vidReq = 0;
        applyStimulus();
        checkOutput("post_clear_valid", 32'(obsVidValid), 32'(1));
        checkOutput("post_clear_data", 32'(obsVidData), 32'(CV));

        // Reset while the sweep sits at (2,1).
        clearStart = 1;
        applyStimulus();
        clearStart = 0;
        repeat (6) applyStimulus();
        reset = 1;
        applyStimulus();
        checkOutput("mid_sweep_x", 32'(obsMemX), 32'(2));
        checkOutput("mid_sweep_y", 32'(obsMemY), 32'(1));
        reset = 0;
        applyStimulus();
        checkOutput("restart_x", 32'(obsMemX), 32'(0));
        checkOutput("restart_y", 32'(obsMemY), 32'(0));
        checkOutput("restart_we", 32'(obsMemWe), 32'(1));
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (!obsClearing) break;
            cnt++;
        end
        checkOutput("restart_len", 32'(cnt), 32'(W * H));

        // Random traffic, including out-of-range rows and occasional clears.
        gameActive = 0;
        for (int i = 0; i < 800; i++) begin
            if (mAck) gameActive = 0;
            if (!gameActive && $urandom_range(0, 2) == 0) begin
                gameActive = 1;
                gameWe    = 1'($urandom_range(0, 1));
                gameX     = 2'($urandom_range(0, 3));
                gameY     = 2'($urandom_range(0, 3));
                gameWdata = BD'($urandom_range(0, 7));
            end
            gameReq    = gameActive;
            vidReq     = ($urandom_range(0, 3) != 0);
            vidX       = 2'($urandom_range(0, 3));
            vidY       = 2'($urandom_range(0, 3));
            clearStart = ($urandom_range(0, 79) == 0);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
